pwm_duty_mon: RTL

PWM_DUTY_MON -- requirements
Module: pwm_duty_mon

---
 rtl/pwm_mon_pkg.sv | 29 ++
 rtl/pwm_edge_sync.sv | 30 +++
 rtl/pwm_duty_mon.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_mon_pkg.sv
// Shared types and helpers for the PWM duty monitor.
package pwm_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } mon_state_t;

    localparam logic [2:0] FC_NONE       = 3'd0;
    localparam logic [2:0] FC_HIGH_SHORT = 3'd1;
    localparam logic [2:0] FC_HIGH_LONG  = 3'd2;
    localparam logic [2:0] FC_PERIOD     = 3'd3;
    localparam logic [2:0] FC_TIMEOUT    = 3'd4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    // Sum that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the looped-back PWM plus rise/fall pulses.
module pwm_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_duty_mon.sv
// PWM duty/period monitor: measures high time and period of the looped-back
// PWM and raises a sticky fault on out-of-range values or a lost signal.
// Optional macro PWM_MON_PERIOD_CHK_EN enables the period check (code 3).
module pwm_duty_mon
    import pwm_mon_pkg::*;
#(
    parameter logic [15:0] HIGH_MIN   = 16'd800,
    parameter logic [15:0] HIGH_MAX   = 16'd840,
    parameter logic [15:0] PERIOD_NOM = 16'd1025,
    parameter logic [15:0] PERIOD_TOL = 16'd8,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic        i_clk_50m,
    input  logic        i_rst,
    input  logic        i_pwm,
    input  logic        i_mon_en,
    input  logic        i_fault_clr,
    output logic [15:0] o_high_cnt,
    output logic [15:0] o_period_cnt,
    output logic        o_meas_valid,
    output logic        o_fault,
    output logic [2:0]  o_fault_code
);

    mon_state_t  r_state;
    mon_state_t  w_state_nxt;

    logic        w_rise;
    logic        w_fall;
    logic        w_no_edge;

    logic [15:0] r_high;
    logic [15:0] r_low;
    logic [15:0] r_age;
    logic [15:0] r_high_out;
    logic [15:0] r_period_out;
    logic        r_meas_valid;
    logic        r_fault;
    logic [2:0]  r_fault_code;

    logic [15:0] w_period_sum;
    logic        w_age_done;
    logic        w_period_err;
    logic [2:0]  w_new_code;

    logic        w_load_high;
    logic        w_inc_high;
    logic        w_load_low;
    logic        w_inc_low;
    logic        w_inc_age;
    logic        w_latch;
    logic        w_timeout;

    pwm_edge_sync u_edge_sync (
        .i_clk   (i_clk_50m),
        .i_rst   (i_rst),
        .i_async (i_pwm),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_no_edge    = ~(w_rise | w_fall);
    assign w_period_sum = sat_add(r_high, r_low);
    assign w_age_done   = (r_age == (TIMEOUT - 16'd1));

    // FSM state register.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; disabling forces IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_mon_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_nxt = ST_WAIT_RISE;
                ST_WAIT_RISE: if (w_rise) w_state_nxt = ST_MEAS_HIGH;
                ST_MEAS_HIGH: begin
                    if (w_timeout)   w_state_nxt = ST_WAIT_RISE;
                    else if (w_fall) w_state_nxt = ST_MEAS_LOW;
                end
                ST_MEAS_LOW: begin
                    if (w_timeout)   w_state_nxt = ST_WAIT_RISE;
                    else if (w_rise) w_state_nxt = ST_MEAS_HIGH;
                end
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: counter controls, latch strobe and timeout detect.
    always_comb begin
        w_load_high = 1'b0;
        w_inc_high  = 1'b0;
        w_load_low  = 1'b0;
        w_inc_low   = 1'b0;
        w_inc_age   = 1'b0;
        w_latch     = 1'b0;
        w_timeout   = 1'b0;
        if (i_mon_en) begin
            case (r_state)
                ST_WAIT_RISE: w_load_high = w_rise;
                ST_MEAS_HIGH: begin
                    w_inc_high = ~w_fall;
                    w_load_low = w_fall;
                    w_inc_age  = w_no_edge;
                    w_timeout  = w_no_edge & w_age_done;
                end
                ST_MEAS_LOW: begin
                    w_inc_low   = ~w_rise;
                    w_latch     = w_rise;
                    w_load_high = w_rise;
                    w_inc_age   = w_no_edge;
                    w_timeout   = w_no_edge & w_age_done;
                end
                default: ;
            endcase
        end
    end

    // High/low counters and the latched measurement with its valid pulse.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_high       <= '0;
            r_low        <= '0;
            r_high_out   <= '0;
            r_period_out <= '0;
            r_meas_valid <= 1'b0;
        end else begin
            if (w_load_high)               r_high <= 16'd1;
            else if (w_inc_high)           r_high <= sat_inc(r_high);
            else if (r_state == ST_IDLE)   r_high <= '0;

            if (w_load_low)                r_low <= 16'd1;
            else if (w_inc_low)            r_low <= sat_inc(r_low);
            else if (r_state == ST_IDLE)   r_low <= '0;

            r_meas_valid <= w_latch;
            if (w_latch) begin
                r_high_out   <= r_high;
                r_period_out <= w_period_sum;
            end
        end
    end

    // Cycles since the last edge while measuring; cleared by any edge.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst || !w_inc_age) begin
            r_age <= '0;
        end else begin
            r_age <= sat_inc(r_age);
        end
    end

`ifdef PWM_MON_PERIOD_CHK_EN
    logic        r_first;
    logic [15:0] w_period_dev;

    // Marks the first latch after (re)arming, whose period is only partial.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst || r_state == ST_IDLE || w_timeout) begin
            r_first <= 1'b1;
        end else if (w_latch) begin
            r_first <= 1'b0;
        end
    end

    assign w_period_dev = (w_period_sum >= PERIOD_NOM) ? (w_period_sum - PERIOD_NOM)
                                                       : (PERIOD_NOM - w_period_sum);
    assign w_period_err = ~r_first & (w_period_dev > PERIOD_TOL);
`else
    // Period limits stay on the interface so both builds share one instance form.
    logic w_unused_period_cfg;
    assign w_unused_period_cfg = ^{PERIOD_NOM, PERIOD_TOL};
    assign w_period_err        = 1'b0;
`endif

    // Prioritised fault detection: timeout > period > high long > high short.
    always_comb begin
        w_new_code = FC_NONE;
        if (w_timeout)                          w_new_code = FC_TIMEOUT;
        else if (w_latch && w_period_err)       w_new_code = FC_PERIOD;
        else if (w_latch && r_high > HIGH_MAX)  w_new_code = FC_HIGH_LONG;
        else if (w_latch && r_high < HIGH_MIN)  w_new_code = FC_HIGH_SHORT;
    end

    // Sticky first-wins fault; a fault detected alongside a clear takes effect.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
        end else if (i_mon_en) begin
            if (w_new_code != FC_NONE && (!r_fault || i_fault_clr)) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_new_code;
            end else if (i_fault_clr) begin
                r_fault      <= 1'b0;
                r_fault_code <= FC_NONE;
            end
        end
    end

    assign o_high_cnt   = r_high_out;
    assign o_period_cnt = r_period_out;
    assign o_meas_valid = r_meas_valid;
    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;

endmodule
